io_int_ctrl: RTL

IO_INT_CTRL -- requirements
Module: io_int_ctrl

---
 rtl/io_int_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/io_int_ctrl.sv
// Memory-mapped interrupt controller: edge-detected sources, per-source mask,
// pending and in-service registers, fixed priority (src[0] highest) with
// nesting by strictly higher-priority sources, and a two-state request FSM.
// Data/address vectors are big-endian [0:W-1]; the last index is the LSB.
module io_int_ctrl #(
    parameter int ARCH_WIDTH = 32,
    parameter int NUM_SRC    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:NUM_SRC-1]    src,
    input  logic [0:ARCH_WIDTH-1] addr,
    input  logic                  we,
    input  logic [0:ARCH_WIDTH-1] din,
    output logic [0:ARCH_WIDTH-1] dout,
    output logic                  int_req,
    input  logic                  int_ack,
    output logic [3:0]            int_id
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state;
    logic [0:NUM_SRC-1] mask, pending, isr, src_q;
    logic               armed;

    logic [1:0]         sel;
    logic [0:NUM_SRC-1] wr_bits, src_rise, eligible, ack_oh;
    logic [0:NUM_SRC-1] mask_nxt, pend_nxt, isr_nxt, isr_eoi;
    logic               elig_any, ack_take;
    logic [3:0]         ack_id;
    logic [ARCH_WIDTH-1:0] rd_val;
    logic [3:0]         isr_f, pend_f;

    // Only the word-select bits of addr and the low NUM_SRC bits of din matter.
    logic unused_bits;
    assign unused_bits = ^{addr[0:ARCH_WIDTH-5], addr[ARCH_WIDTH-2:ARCH_WIDTH-1], din};

    assign sel     = addr[ARCH_WIDTH-4:ARCH_WIDTH-3];
    assign wr_bits = din[ARCH_WIDTH-NUM_SRC:ARCH_WIDTH-1];

    // Rising edges; suppressed for the first cycle after reset so a line
    // held high through reset release does not fire.
    assign src_rise = armed ? (src & ~src_q) : '0;

    // Eligible set: unmasked pending sources above the highest in-service one,
    // and the lowest eligible index as a one-hot plus its ID.
    always_comb begin
        logic ok, found;
        ok       = 1'b1;
        found    = 1'b0;
        eligible = '0;
        ack_oh   = '0;
        ack_id   = 4'hF;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (isr[i]) ok = 1'b0;
            eligible[i] = pending[i] & ~mask[i] & ok;
            if (eligible[i] && !found) begin
                ack_oh[i] = 1'b1;
                ack_id    = 4'(i);
                found     = 1'b1;
            end
        end
        elig_any = found;
    end

    assign ack_take = (state == REQ) && int_ack && elig_any;

    // EOI retires the highest-priority in-service bit only.
    always_comb begin
        logic found;
        found   = 1'b0;
        isr_eoi = isr;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (isr[i] && !found) begin
                isr_eoi[i] = 1'b0;
                found      = 1'b1;
            end
        end
    end

    // Next register values; EOI is applied before the ack sets its bit, and a
    // new edge beats any clear of the same pending bit.
    always_comb begin
        mask_nxt = mask;
        pend_nxt = pending;
        isr_nxt  = isr;
        if (we && sel == 2'd1) mask_nxt = wr_bits;
        if (we && sel == 2'd2) pend_nxt = pend_nxt & ~wr_bits;
        if (ack_take)          pend_nxt = pend_nxt & ~ack_oh;
        pend_nxt = pend_nxt | src_rise;
        if (we && sel == 2'd3) isr_nxt = isr_eoi;
        if (ack_take)          isr_nxt = isr_nxt | ack_oh;
    end

    // Register state and the request FSM with registered int_req / int_id.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            int_req <= 1'b0;
            int_id  <= 4'hF;
            mask    <= '1;
            pending <= '0;
            isr     <= '0;
            src_q   <= '0;
            armed   <= 1'b0;
        end else begin
            src_q   <= src;
            armed   <= 1'b1;
            mask    <= mask_nxt;
            pending <= pend_nxt;
            isr     <= isr_nxt;
            case (state)
                IDLE: begin
                    if (elig_any) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_id  <= elig_any ? ack_id : 4'hF;
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end else if (!elig_any) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read mux; fields are right-justified, unused bits zero.
    always_comb begin
        isr_f  = '0;
        pend_f = '0;
        isr_f[NUM_SRC-1:0]  = isr;
        pend_f[NUM_SRC-1:0] = pending;
        rd_val = '0;
        case (sel)
            2'd0:    rd_val[11:0] = {isr_f, pend_f, int_id};
            2'd1:    rd_val[NUM_SRC-1:0] = mask;
            2'd2:    rd_val[NUM_SRC-1:0] = pending;
            default: rd_val = '0;
        endcase
    end

    assign dout = rd_val;

endmodule
